// File: rtl/i2c_slave.sv
// Receive-only I2C byte receiver: oversamples SCL/SDA on clk, shifts bits in MSB-first,
// presents each completed byte with a level valid flag and optionally ACKs on the 9th pulse.
module i2c_slave #(
  parameter bit ACK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] data_out,
  output logic       valid
);

  typedef enum logic [1:0] {
    RECV     = 2'd0,
    ACK_WAIT = 2'd1,
    ACK      = 2'd2
  } state_t;

  // Bit 0 carries scl, bit 1 carries sda.
  logic [1:0] line_raw;
  logic [1:0] line_cur;
  logic [1:0] line_prev;

  assign line_raw = {sda, scl};

  // Two synchroniser flops plus a history flop per line; reset to the idle-bus level
  // so that leaving reset never looks like an edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic [2:0] pipe_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          pipe_reg <= 3'b111;
        end else begin
          pipe_reg <= {pipe_reg[1:0], line_raw[gi]};
        end
      end
      assign line_cur[gi]  = pipe_reg[1];
      assign line_prev[gi] = pipe_reg[2];
    end
  endgenerate

  logic scl_cur, scl_prev, sda_cur, sda_prev;
  assign scl_cur  = line_cur[0];
  assign scl_prev = line_prev[0];
  assign sda_cur  = line_cur[1];
  assign sda_prev = line_prev[1];

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = ~scl_prev & scl_cur;
  assign scl_fall  = scl_prev & ~scl_cur;
  assign start_det = scl_prev & scl_cur & sda_prev & ~sda_cur;
  assign stop_det  = scl_prev & scl_cur & ~sda_prev & sda_cur;

  state_t     state_reg, state_next;
  logic [2:0] count_reg, count_next;
  logic [6:0] shift_reg, shift_next;
  logic [7:0] data_reg, data_next;
  logic       valid_reg, valid_next;
  logic       drive_reg, drive_next;
  logic [7:0] byte_next;

  assign byte_next = {shift_reg, sda_cur};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RECV;
      count_reg <= 3'd0;
      shift_reg <= 7'd0;
      data_reg  <= 8'h00;
      valid_reg <= 1'b0;
      drive_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      drive_reg <= drive_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    drive_next = drive_reg;

    if (start_det) begin
      state_next = RECV;
      count_next = 3'd0;
      drive_next = 1'b0;
      valid_next = 1'b0;
    end else if (stop_det) begin
      state_next = RECV;
      count_next = 3'd0;
      drive_next = 1'b0;
    end else begin
      case (state_reg)
        RECV: begin
          if (scl_rise) begin
            shift_next = byte_next[6:0];
            if (count_reg == 3'd7) begin
              data_next  = byte_next;
              valid_next = 1'b1;
              count_next = 3'd0;
              if (ACK_EN) begin
                state_next = ACK_WAIT;
              end
            end else begin
              // First bit of a new byte retires the previous byte's valid.
              if (count_reg == 3'd0) begin
                valid_next = 1'b0;
              end
              count_next = count_reg + 3'd1;
            end
          end
        end
        ACK_WAIT: begin
          if (scl_fall) begin
            drive_next = 1'b1;
            state_next = ACK;
          end
        end
        ACK: begin
          if (scl_fall) begin
            drive_next = 1'b0;
            state_next = RECV;
          end
        end
        default: begin
          state_next = RECV;
          drive_next = 1'b0;
        end
      endcase
    end
  end

  assign sda      = drive_reg ? 1'b0 : 1'bz;
  assign data_out = data_reg;
  assign valid    = valid_reg;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed plus randomized bus-level stimulus for i2c_slave, checked against a byte-level
// model of what the receiver should have delivered.
module tb_i2c_slave;

  logic       clk;
  logic       reset;
  logic       scl;
  logic       sda_m;
  wire        sda;
  logic [7:0] data_out;
  logic       valid;

  pullup (sda);
  assign sda = sda_m ? 1'bz : 1'b0;

  i2c_slave #(.ACK_EN(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .data_out (data_out),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Bus-level expectations: last delivered byte, valid flag, bits of the byte in flight.
  logic [7:0] exp_data;
  logic       exp_valid;
  int         m_count;
  int         m_acc;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_data"}, data_out, exp_data);
    chk({tag, "_valid"}, {7'd0, valid}, {7'd0, exp_valid});
  endtask

  task automatic model_rise(input logic b);
    if (m_count == 0) exp_valid = 1'b0;
    m_acc   = (m_acc * 2 + int'(b)) % 256;
    m_count = m_count + 1;
    if (m_count == 8) begin
      exp_data  = m_acc[7:0];
      exp_valid = 1'b1;
      m_count   = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    scl   = 1'b1;
    sda_m = 1'b1;
    #20;
    reset = 1'b0;
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    m_count   = 0;
    m_acc     = 0;
    #10;
    chk_out("reset");
    chk("reset_sda", {7'd0, sda}, 8'h01);
  endtask

  // Send the top n bits of b MSB-first; leaves scl high.
  task automatic send_bits(input logic [7:0] b, input int n, input bit simul);
    logic [7:0] pre_data;
    logic       pre_valid;
    logic       bitv;
    for (int i = 0; i < n; i++) begin
      bitv = b[7-i];
      if (simul) begin
        scl   = 1'b0;
        sda_m = bitv;
        #50;
      end else begin
        scl = 1'b0;
        #20;
        sda_m = bitv;
        #30;
      end
      scl       = 1'b1;
      pre_data  = exp_data;
      pre_valid = exp_valid;
      model_rise(bitv);
      if (m_count == 0) begin
        #20;
        chk("lat_early_data", data_out, pre_data);
        chk("lat_early_valid", {7'd0, valid}, {7'd0, pre_valid});
        #10;
        chk_out("byte_done");
        #20;
      end else begin
        #50;
        chk_out("bit");
      end
    end
  endtask

  task automatic ack_pulse();
    scl = 1'b0;
    #20;
    sda_m = 1'b1;
    #30;
    scl = 1'b1;
    #30;
    chk("ack_sda", {7'd0, sda}, 8'h00);
    chk_out("ack");
    #20;
  endtask

  // STOP straight after a byte whose last bit was 0 (scl still high).
  task automatic stop_direct();
    #10;
    sda_m   = 1'b1;
    m_count = 0;
    #40;
    chk_out("stop");
    chk("stop_sda", {7'd0, sda}, 8'h01);
  endtask

  // START straight after a byte whose last bit was 1 (scl still high).
  task automatic start_direct();
    #10;
    sda_m     = 1'b0;
    m_count   = 0;
    exp_valid = 1'b0;
    #40;
    chk_out("start");
  endtask

  // Repeated-start shape from mid-byte: the setup SCL pulse is itself sampled as a bit.
  task automatic start_cond();
    scl = 1'b0;
    #20;
    sda_m = 1'b1;
    #30;
    scl = 1'b1;
    model_rise(1'b1);
    #30;
    sda_m     = 1'b0;
    m_count   = 0;
    exp_valid = 1'b0;
    #40;
    chk_out("rstart");
  endtask

  initial begin
    logic [7:0] b;
    int         op;
    int         n;
    bit         simul;

    // T1 reset
    do_reset();

    // T2 single byte, scl left high
    send_bits(8'hA5, 8, 1'b0);
    #100;
    chk_out("hold");
    ack_pulse();

    // T3 back-to-back with ACK
    send_bits(8'h3C, 8, 1'b0);
    ack_pulse();
    send_bits(8'hC3, 8, 1'b0);
    ack_pulse();

    // T4 partial byte then START, then a full byte
    send_bits(8'hF0, 4, 1'b0);
    start_cond();
    send_bits(8'h81, 8, 1'b0);
    ack_pulse();

    // STOP and START straight after a byte, no ACK pulse
    send_bits(8'h24, 8, 1'b0);
    stop_direct();
    // T5 SDA falls together with SCL: must not be seen as START
    send_bits(8'h3E, 8, 1'b1);
    ack_pulse();
    send_bits(8'h67, 8, 1'b0);
    start_direct();

    // T6 reset mid-byte
    send_bits(8'hFF, 5, 1'b0);
    do_reset();
    send_bits(8'h5A, 8, 1'b0);
    ack_pulse();

    // Randomized mix of complete bytes, partial bytes and bus conditions
    for (int k = 0; k < 20; k++) begin
      op    = int'($urandom_range(0, 3));
      b     = 8'($urandom);
      simul = 1'($urandom_range(0, 1));
      case (op)
        0: begin
          send_bits(b, 8, simul);
          ack_pulse();
        end
        1: begin
          n = int'($urandom_range(1, 4));
          send_bits(b, n, simul);
          start_cond();
        end
        2: begin
          b[0] = 1'b0;
          send_bits(b, 8, simul);
          stop_direct();
        end
        default: begin
          b[0] = 1'b1;
          send_bits(b, 8, simul);
          start_direct();
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
